down_timer: RTL and testbench

- Programmable down-counting timer for the MCU datapath, written by the store path (data_mem write data) and read back over the load path.
- Counts prescaled clock ticks from a loaded value down to zero, then raises an expire flag and an interrupt.
- Runs in one-shot or auto-reload mode.
- It is the consumer/countdown counterpart to the free-running cycle counter.

---
 rtl/down_timer.sv | 133 +++++++++++++
 tb/tb_down_timer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Programmable down-counting timer: LOAD/CTRL/STATUS written from the store path, COUNT counts prescaled ticks to zero.
// Define DOWN_TIMER_IRQ_PULSE_EN for a one-cycle registered irq pulse per expire instead of a level irq.
module down_timer #(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] data_mem,
  input  logic [1:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] A_LOAD   = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   load_q, count_q;
  logic               en_q, ar_q, ie_q, expired_q;
  logic [PRESC_W-1:0] presc_q, presc_cnt_q;

  logic load_wr, ctrl_wr, status_wr;
  logic running, start, stop, tick, expire;

  assign load_wr   = wr_en && (wr_addr == A_LOAD);
  assign ctrl_wr   = wr_en && (wr_addr == A_CTRL);
  assign status_wr = wr_en && (wr_addr == A_STATUS);

  assign running = (state_q == RUN);
  assign start   = ctrl_wr &&  data_mem[0] && !running;
  // A disable landing on a tick edge suppresses that tick entirely.
  assign stop    = ctrl_wr && !data_mem[0] &&  running;
  assign tick    = running && !stop && (presc_cnt_q == presc_q);
  assign expire  = tick && (count_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN: begin
        if (stop)                 state_d = IDLE;
        else if (expire && !ar_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; a later assignment in the block takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q      <= '0;
      count_q     <= '0;
      en_q        <= 1'b0;
      ar_q        <= 1'b0;
      ie_q        <= 1'b0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      expired_q   <= 1'b0;
    end else begin
      if (load_wr) load_q <= data_mem;

      // While running, LOAD only reaches COUNT through a reload, using the value held before this edge.
      if (running) begin
        if (tick) begin
          if (count_q != '0) count_q <= count_q - WIDTH'(1);
          else if (ar_q)     count_q <= load_q;
        end
      end else if (load_wr) begin
        count_q <= data_mem;
      end else if (start && (state_q == DONE)) begin
        count_q <= load_q;
      end

      if (start || tick)        presc_cnt_q <= '0;
      else if (running && !stop) presc_cnt_q <= presc_cnt_q + PRESC_W'(1);

      if (ctrl_wr) begin
        en_q    <= data_mem[0];
        ar_q    <= data_mem[1];
        ie_q    <= data_mem[2];
        presc_q <= data_mem[8 +: PRESC_W];
      end
      if (expire && !ar_q) en_q <= 1'b0;

      // Expire beats a simultaneous software clear.
      if (expire)                         expired_q <= 1'b1;
      else if (status_wr && data_mem[0])  expired_q <= 1'b0;
    end
  end

`ifdef DOWN_TIMER_IRQ_PULSE_EN
  logic irq_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= expire && ie_q;
  end
`endif

  always_comb begin
    rd_data = '0;
    unique case (rd_addr)
      A_LOAD:  rd_data = load_q;
      A_CTRL: begin
        rd_data[0]             = en_q;
        rd_data[1]             = ar_q;
        rd_data[2]             = ie_q;
        rd_data[8 +: PRESC_W]  = presc_q;
      end
      A_COUNT:  rd_data = count_q;
      A_STATUS: rd_data[0] = expired_q;
      default:  rd_data = '0;
    endcase
`ifdef DOWN_TIMER_IRQ_PULSE_EN
    irq = irq_q;
`else
    irq = expired_q && ie_q;
`endif
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed table, hand sequences, and random stimulus against a tick-countdown model.
// Follows DOWN_TIMER_IRQ_PULSE_EN to pick the expected irq behaviour.
module tb_down_timer;

`ifdef DOWN_TIMER_IRQ_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] data_mem;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  down_timer #(.WIDTH(32), .PRESC_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .data_mem (data_mem),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Reference model: running/finished flags plus a countdown of cycles to the next tick.
  logic [31:0] m_load, m_count;
  logic [7:0]  m_presc;
  bit          m_ar, m_ie, m_expired, m_pulse, m_running, m_finished;
  int          m_wait;

  task automatic model_reset();
    m_load = 0; m_count = 0; m_presc = 0;
    m_ar = 0; m_ie = 0; m_expired = 0; m_pulse = 0;
    m_running = 0; m_finished = 0; m_wait = 0;
  endtask

  task automatic model_step(input bit w, input logic [1:0] a, input logic [31:0] d);
    bit was_running, tick, exp, old_ie;
    if (!reset) return;
    was_running = m_running;
    old_ie = m_ie;
    tick = 0;
    exp = 0;
    if (m_running) begin
      if (w && a == 2'd1 && !d[0]) m_running = 0;
      else begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          tick = 1;
          m_wait = int'(m_presc) + 1;
        end
      end
    end
    if (tick) begin
      if (m_count == 0) begin
        exp = 1;
        if (m_ar) m_count = m_load;
        else begin
          m_running = 0;
          m_finished = 1;
        end
      end else m_count = m_count - 1;
    end
    if (w && a == 2'd0) begin
      if (!was_running) m_count = d;
      m_load = d;
    end
    if (w && a == 2'd1) begin
      m_ar = d[1];
      m_ie = d[2];
      m_presc = d[15:8];
      if (!was_running && d[0]) begin
        m_running = 1;
        m_wait = int'(d[15:8]) + 1;
        if (m_finished) m_count = m_load;
        m_finished = 0;
      end
    end
    if (exp) m_expired = 1;
    else if (w && a == 2'd3 && d[0]) m_expired = 0;
    m_pulse = exp && old_ie;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_load;
      2'd1:    return {16'd0, m_presc, 5'd0, m_ie, m_ar, m_running};
      2'd2:    return m_count;
      default: return {31'd0, m_expired};
    endcase
  endfunction

  function automatic bit model_irq();
    return PULSE ? m_pulse : (m_expired && m_ie);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit w, input logic [1:0] a, input logic [31:0] d);
    wr_en = w; wr_addr = a; data_mem = d;
    @(posedge clk);
    model_step(w, a, d);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0);
  endtask

  task automatic expect_rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(nm, rd_data, exp);
  endtask

  task automatic expect_irq(input string nm, input bit exp);
    #0;
    check(nm, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic expect_all_zero(input string nm);
    for (int a = 0; a < 4; a++) expect_rd(nm, 2'(a), 32'd0);
    expect_irq(nm, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  typedef struct {
    bit          w;
    logic [1:0]  wa;
    logic [31:0] d;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  a;
    int          r;

    // One-shot, no prescale: COUNT 3,2,1,0 then expire on the 4th tick.
    tbl[0] = '{1'b1, 2'd0, 32'd3, 2'd2, 32'd3, 1'b0};
    tbl[1] = '{1'b1, 2'd1, 32'h5, 2'd2, 32'd3, 1'b0};
    tbl[2] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd2, 1'b0};
    tbl[3] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd1, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0};
    tbl[5] = '{1'b0, 2'd0, 32'd0, 2'd3, 32'd1, 1'b1};
    tbl[6] = '{1'b0, 2'd0, 32'd0, 2'd1, 32'h4, !PULSE};
    tbl[7] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, !PULSE};
    tbl[8] = '{1'b1, 2'd3, 32'd1, 2'd3, 32'd0, 1'b0};
    tbl[9] = '{1'b0, 2'd0, 32'd0, 2'd1, 32'h4, 1'b0};

    reset = 1'b0; wr_en = 1'b0; wr_addr = 0; data_mem = 0; rd_addr = 0;
    model_reset();
    #12;
    expect_all_zero("reset_state");
    #8;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].w, tbl[i].wa, tbl[i].d);
      expect_rd($sformatf("oneshot_rd[%0d]", i), tbl[i].ra, tbl[i].exp_rd);
      expect_irq($sformatf("oneshot_irq[%0d]", i), tbl[i].exp_irq);
    end

    // Auto-reload, PRESC=3: expire every 12 cycles, clears, and collisions.
    do_reset();
    step(1'b1, 2'd0, 32'd2);
    step(1'b1, 2'd1, 32'h307);
    idle(11);
    expect_rd("ar_c11_status", 2'd3, 32'd0);
    idle(1);
    expect_rd("ar_c12_status", 2'd3, 32'd1);
    expect_irq("ar_c12_irq", 1'b1);
    expect_rd("ar_c12_count", 2'd2, 32'd2);
    step(1'b1, 2'd3, 32'd1);
    expect_rd("ar_c13_clear", 2'd3, 32'd0);
    expect_irq("ar_c13_irq", 1'b0);
    idle(10);
    expect_rd("ar_c23_status", 2'd3, 32'd0);
    idle(1);
    expect_rd("ar_c24_status", 2'd3, 32'd1);
    step(1'b1, 2'd3, 32'd1);
    idle(10);
    expect_rd("col_c35_status", 2'd3, 32'd0);
    step(1'b1, 2'd3, 32'd1);
    expect_rd("col_clear_vs_expire", 2'd3, 32'd1);
    expect_irq("col_clear_vs_expire_irq", 1'b1);
    step(1'b1, 2'd3, 32'd1);
    idle(10);
    expect_rd("col_c47_count", 2'd2, 32'd0);
    step(1'b1, 2'd1, 32'h306);
    expect_rd("col_dis_status", 2'd3, 32'd0);
    expect_rd("col_dis_count", 2'd2, 32'd0);
    expect_rd("col_dis_ctrl", 2'd1, 32'h306);
    idle(8);
    expect_rd("col_idle_status", 2'd3, 32'd0);
    expect_rd("col_idle_count", 2'd2, 32'd0);

    // LOAD rewrite while running only takes effect at the next reload.
    do_reset();
    step(1'b1, 2'd0, 32'd5);
    step(1'b1, 2'd1, 32'h3);
    idle(2);
    expect_rd("lrw_count3", 2'd2, 32'd3);
    step(1'b1, 2'd0, 32'd1);
    expect_rd("lrw_e3", 2'd2, 32'd2);
    expect_rd("lrw_load", 2'd0, 32'd1);
    idle(1); expect_rd("lrw_e4", 2'd2, 32'd1);
    idle(1); expect_rd("lrw_e5", 2'd2, 32'd0);
    idle(1); expect_rd("lrw_e6", 2'd2, 32'd1);
    expect_rd("lrw_e6_status", 2'd3, 32'd1);
    idle(1); expect_rd("lrw_e7", 2'd2, 32'd0);
    idle(1); expect_rd("lrw_e8", 2'd2, 32'd1);

    // LOAD=0, AR, PRESC=1: expire every other cycle.
    do_reset();
    step(1'b1, 2'd0, 32'd0);
    step(1'b1, 2'd1, 32'h107);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      expect_rd($sformatf("lz_status[%0d]", k), 2'd3, {31'd0, k >= 2});
      expect_irq($sformatf("lz_irq[%0d]", k),
                 PULSE ? (k >= 2 && k % 2 == 0) : (k >= 2));
    end

    // Reset in the middle of an auto-reload run with the expire flag set.
    do_reset();
    step(1'b1, 2'd0, 32'd2);
    step(1'b1, 2'd1, 32'h7);
    idle(4);
    expect_rd("mid_count", 2'd2, 32'd1);
    expect_rd("mid_status", 2'd3, 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    expect_all_zero("mid_reset_held");
    idle(2);
    reset = 1'b1;
    idle(3);
    expect_all_zero("mid_reset_after");

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      d = $urandom;
      a = 2'd0;
      if (r <= 4) begin
        step(1'b0, 2'd0, d);
      end else begin
        if (r == 5) begin
          a = 2'd0;
          if ($urandom_range(0, 19) != 0) d = $urandom_range(0, 6);
        end else if (r <= 7) begin
          a = 2'd1;
          d[0] = ($urandom_range(0, 3) != 0);
          if (m_running && d[0]) d[15:8] = m_presc;
          else d[15:8] = 8'($urandom_range(0, 3));
        end else if (r == 8) a = 2'd3;
        else a = 2'd2;
        step(1'b1, a, d);
      end
      rd_addr = 2'($urandom_range(0, 3));
      #1;
      check($sformatf("rnd_rd[a=%0d,c=%0d]", rd_addr, c), rd_data, model_read(rd_addr));
      check($sformatf("rnd_irq[c=%0d]", c), {31'd0, irq}, {31'd0, model_irq()});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
